// File: rtl/word_mux_serializer_if.sv
// Frame-in / word-out handshake bundle for word_mux_serializer_ctrl.
// The master side (source of frames, sink of words) drives in_* and out_ready.
interface word_mux_serializer_if #(
   parameter int DWIDTH   = 8,
   parameter int WORDS_IN = 16,
   parameter int IDXW     = 4
) ();
   logic                       in_valid;
   logic                       in_ready;
   logic [DWIDTH*WORDS_IN-1:0] in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [DWIDTH-1:0]          out_data;
   logic [IDXW-1:0]            out_idx;
   logic                       out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/word_mux_serializer_ctrl.sv
// Captures one WORDS_IN-word frame and serializes it, index 0 first, through a
// LAYERS-deep registered mux tree; one shared advance keeps tree and tags coherent.
module word_mux_serializer_ctrl #(
   parameter int DWIDTH   = 8,
   parameter int WORDS_IN = 16,
   parameter int SEL_NUM  = 2,
   parameter int LAYERS   = 2,
   parameter int IDXW     = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_flush,
   output logic                 o_busy,
   word_mux_serializer_if.slave bus
);
   localparam int              N_TO_1   = 1 << SEL_NUM;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS_IN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_busy;
   logic                       r_in_ready;
   logic [IDXW-1:0]            r_cnt;
   logic [DWIDTH*WORDS_IN-1:0] r_cap;
   logic [LAYERS-1:0]          r_vld;
   logic [LAYERS-1:0]          r_last;
   logic [IDXW-1:0]            r_idx [LAYERS];
   logic                       w_adv;
   logic                       w_issue;
   logic                       w_accept;
   logic                       w_out_fire;

   // A stalled output word freezes every stage, so no word can be overtaken.
   assign w_adv      = !r_vld[LAYERS-1] || bus.out_ready;
   assign w_issue    = (r_state == S_RUN) && w_adv;
   assign w_accept   = (r_state == S_IDLE) && bus.in_valid && !i_flush;
   assign w_out_fire = r_vld[LAYERS-1] && bus.out_ready;

   // State register with registered busy/in_ready decodes
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_in_ready <= (w_state_nxt == S_IDLE);
      end
   end

   // Next-state logic; flush wins over everything including a pending accept
   always_comb begin
      w_state_nxt = r_state;
      if (i_flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) w_state_nxt = S_RUN;
               else              w_state_nxt = S_IDLE;
            end
            S_RUN: begin
               if (w_issue && (r_cnt == LAST_IDX)) w_state_nxt = S_DRAIN;
               else                                w_state_nxt = S_RUN;
            end
            S_DRAIN: begin
               if (w_out_fire && r_last[LAYERS-1]) w_state_nxt = S_IDLE;
               else                                w_state_nxt = S_DRAIN;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Issue counter: index of the next word pushed into layer 0
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (i_flush || w_accept) begin
         r_cnt <= '0;
      end else if (w_issue) begin
         r_cnt <= r_cnt + IDXW'(1);
      end
   end

   // Frame capture, sampled only on the accept edge
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_cap <= bus.in_data;
      end
   end

   // Valid/index/last tags travel alongside the data through the tree
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_vld  <= '0;
         r_last <= '0;
         for (int p = 0; p < LAYERS; p++) begin
            r_idx[p] <= '0;
         end
      end else if (i_flush) begin
         r_vld  <= '0;
         r_last <= '0;
      end else if (w_adv) begin
         r_vld[0]  <= w_issue;
         r_last[0] <= w_issue && (r_cnt == LAST_IDX);
         r_idx[0]  <= r_cnt;
         for (int p = 1; p < LAYERS; p++) begin
            r_vld[p]  <= r_vld[p-1];
            r_last[p] <= r_last[p-1];
            r_idx[p]  <= r_idx[p-1];
         end
      end
   end

   // Layer l reduces groups of N_TO_1 words using base-N digit l of the word index
   for (genvar l = 0; l < LAYERS; l++) begin : g_layer
      localparam int NOUT = WORDS_IN / (N_TO_1 ** (l + 1));
      localparam int NIN  = NOUT * N_TO_1;

      logic [DWIDTH*NIN-1:0]  w_in;
      logic [SEL_NUM-1:0]     w_sel;
      logic [DWIDTH*NOUT-1:0] r_q;

      if (l == 0) begin : g_first
         assign w_in  = r_cap;
         assign w_sel = r_cnt[SEL_NUM-1:0];
      end else begin : g_rest
         assign w_in  = g_layer[l-1].r_q;
         assign w_sel = r_idx[l-1][SEL_NUM*l +: SEL_NUM];
      end

      // Registered N_TO_1:1 selection per output slot
      always_ff @(posedge i_clk) begin
         if (w_adv) begin
            for (int g = 0; g < NOUT; g++) begin
               r_q[DWIDTH*g +: DWIDTH] <= w_in[DWIDTH*(g*N_TO_1 + int'(w_sel)) +: DWIDTH];
            end
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_vld[LAYERS-1];
   assign bus.out_idx   = r_idx[LAYERS-1];
   assign bus.out_last  = r_last[LAYERS-1];
   assign bus.out_data  = g_layer[LAYERS-1].r_q;
   assign o_busy        = r_busy;
endmodule
